// File: rtl/button_pkg.sv
// button_pkg: shared event and per-button state types for the button event scanner
package button_pkg;
   typedef enum logic [1:0] {EVT_PRESS, EVT_RELEASE, EVT_LONG} evt_kind_t;
   typedef enum logic [2:0] {RELEASED, ARMING, HELD, LONG_HELD, DISARMING} btn_state_t;
   typedef struct packed {
      logic [2:0] button;
      evt_kind_t  kind;
   } event_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through synchronous FIFO, pointer wrap tracked by an extra MSB
module event_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_pop, do_push;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop = pop && !empty;
   // a pop in the same cycle frees the slot, so a full queue still accepts the push
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clock)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/button_event_scanner.sv
// button_event_scanner: synchronizes and debounces buttons, emits press/release/long events
module button_event_scanner
   import button_pkg::*;
#(
   parameter int N_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000,
   parameter int FIFO_DEPTH      = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   localparam int BW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_state,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [BW-1:0]        evt_button,
   output logic [1:0]           evt_kind,
   output logic                 overflow,
   input  logic                 overflow_clr
);
   localparam int CMAX = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   logic [N_BUTTONS-1:0] sync1, sync2, s;
   logic [N_BUTTONS-1:0][2:0] raise, pending, clr_mask;
   event_t sel, head, head_raw;
   logic sel_valid, pop, drop, fifo_full, fifo_empty, unused_btn_bits;
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         sync1 <= {N_BUTTONS{ACTIVE_LOW}};
         sync2 <= {N_BUTTONS{ACTIVE_LOW}};
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end
   assign s = ACTIVE_LOW ? ~sync2 : sync2;
   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
      btn_state_t state, state_nx;
      logic [CW-1:0] deb_cnt, deb_nx, hold_cnt, hold_nx;
      logic was_long, was_long_nx;
      logic [2:0] raise_l;
      always_ff @(posedge clock) begin
         if (!rst_n) begin
            state <= RELEASED;
            deb_cnt <= '0;
            hold_cnt <= '0;
            was_long <= 1'b0;
         end else begin
            state <= state_nx;
            deb_cnt <= deb_nx;
            hold_cnt <= hold_nx;
            was_long <= was_long_nx;
         end
      end
      // hold_cnt is left untouched while disarming so a bounce back resumes the long timer
      always_comb begin
         state_nx = state;
         deb_nx = deb_cnt;
         hold_nx = hold_cnt;
         was_long_nx = was_long;
         raise_l = '0;
         case (state)
            RELEASED: if (s[i]) begin
               state_nx = ARMING;
               deb_nx = '0;
            end
            ARMING: if (!s[i]) state_nx = RELEASED;
               else if (deb_cnt == DEB_LAST) begin
                  state_nx = HELD;
                  hold_nx = '0;
                  was_long_nx = 1'b0;
                  raise_l[EVT_PRESS] = 1'b1;
               end else deb_nx = deb_cnt + 1'b1;
            HELD: if (!s[i]) begin
                  state_nx = DISARMING;
                  deb_nx = '0;
               end else if (hold_cnt == LONG_LAST) begin
                  state_nx = LONG_HELD;
                  was_long_nx = 1'b1;
                  raise_l[EVT_LONG] = 1'b1;
               end else hold_nx = hold_cnt + 1'b1;
            LONG_HELD: if (!s[i]) begin
               state_nx = DISARMING;
               deb_nx = '0;
            end
            DISARMING: if (s[i]) state_nx = was_long ? LONG_HELD : HELD;
               else if (deb_cnt == DEB_LAST) begin
                  state_nx = RELEASED;
                  raise_l[EVT_RELEASE] = 1'b1;
               end else deb_nx = deb_cnt + 1'b1;
            default: state_nx = RELEASED;
         endcase
      end
      assign raise[i] = raise_l;
      assign btn_state[i] = state inside {HELD, LONG_HELD, DISARMING};
   end
   // descending scan so the lowest pending button wins
   always_comb begin
      sel_valid = 1'b0;
      sel = '0;
      clr_mask = '0;
      for (int b = N_BUTTONS - 1; b >= 0; b--)
         if (|pending[b]) begin
            sel_valid = 1'b1;
            sel.button = 3'(b);
            sel.kind = pending[b][EVT_PRESS] ? EVT_PRESS : pending[b][EVT_LONG] ? EVT_LONG : EVT_RELEASE;
            clr_mask = '0;
            clr_mask[b][sel.kind] = 1'b1;
         end
   end
   assign pop = evt_valid && evt_ready;
   assign drop = sel_valid && fifo_full && !pop;
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         pending <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | raise;
         overflow <= drop | (overflow & ~overflow_clr);
      end
   end
   event_fifo #(.WIDTH($bits(event_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock),
      .rst_n(rst_n),
      .push (sel_valid),
      .pop  (pop),
      .din  (sel),
      .dout (head_raw),
      .full (fifo_full),
      .empty(fifo_empty)
   );
   assign head = fifo_empty ? '0 : head_raw;
   assign evt_valid = !fifo_empty;
   assign evt_button = head.button[BW-1:0];
   assign evt_kind = head.kind;
   assign unused_btn_bits = ^head.button;
endmodule

// File: tb/tb_button_event_scanner.sv
// tb_button_event_scanner: randomized and scenario stimulus checked against a behavioural event model
module tb_button_event_scanner;
   localparam int D = 4, L = 10, NB = 4, DEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b1, overflow_clr = 1'b0;
   logic [3:0] btn_raw = 4'hF, btn_state;
   logic evt_valid, overflow;
   logic [1:0] evt_button, evt_kind;
   int n_checks = 0, n_fail = 0;
   bit [3:0] m_sync1, m_sync2;
   bit m_pressed[NB], m_long[NB];
   int m_streak[NB], m_hold[NB];
   bit [2:0] m_pend[NB];
   bit m_ovf;
   int q[$];

   button_event_scanner #(
      .N_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_state(btn_state),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_button(evt_button), .evt_kind(evt_kind),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // kinds: 0 press, 1 release, 2 long; queue entries are button*4+kind
   task automatic model_step();
      bit [3:0] sv;
      bit pop, found, drop;
      int code, k;
      if (!rst_n) begin
         m_sync1 = '0; m_sync2 = '0; m_ovf = 0; q.delete();
         for (int b = 0; b < NB; b++) begin
            m_pressed[b] = 0; m_long[b] = 0; m_streak[b] = 0; m_hold[b] = 0; m_pend[b] = '0;
         end
         return;
      end
      sv = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = ~btn_raw;
      pop = q.size() > 0 && evt_ready;
      found = 0;
      code = 0;
      for (int b = 0; b < NB; b++)
         if (!found && m_pend[b] != 0) begin
            found = 1;
            k = m_pend[b][0] ? 0 : m_pend[b][2] ? 2 : 1;
            m_pend[b][k] = 0;
            code = b * 4 + k;
         end
      drop = found && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (found && !drop) q.push_back(code);
      m_ovf = drop ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
      for (int b = 0; b < NB; b++) begin
         if (!m_pressed[b]) begin
            m_streak[b] = sv[b] ? m_streak[b] + 1 : 0;
            if (m_streak[b] == D + 1) begin
               m_pressed[b] = 1; m_streak[b] = 0; m_hold[b] = 0; m_long[b] = 0; m_pend[b][0] = 1;
            end
         end else if (!sv[b]) begin
            m_streak[b]++;
            if (m_streak[b] == D + 1) begin
               m_pressed[b] = 0; m_streak[b] = 0; m_pend[b][1] = 1;
            end
         end else begin
            if (m_streak[b] == 0 && !m_long[b]) begin
               if (m_hold[b] == L - 1) begin
                  m_long[b] = 1; m_pend[b][2] = 1;
               end else m_hold[b]++;
            end
            m_streak[b] = 0;
         end
      end
   endtask

   task automatic compare();
      bit [3:0] exp_state;
      for (int b = 0; b < NB; b++) exp_state[b] = m_pressed[b];
      check("btn_state", 32'(btn_state), 32'(exp_state));
      check("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() > 0) begin
         check("evt_button", 32'(evt_button), 32'(q[0] / 4));
         check("evt_kind", 32'(evt_kind), 32'(q[0] % 4));
      end else if (!rst_n) begin
         check("rst_button", 32'(evt_button), 32'd0);
         check("rst_kind", 32'(evt_kind), 32'd0);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         compare();
      end
   endtask

   function automatic bit any_pend();
      bit a = 0;
      for (int b = 0; b < NB; b++) a |= (m_pend[b] != 0);
      return a;
   endfunction

   initial begin
      btn_raw = 4'b0000;
      cyc(5);
      rst_n = 1'b1;
      cyc(20);
      btn_raw = 4'hF;
      cyc(20);
      for (int t = 0; t < 10; t++) begin
         btn_raw[1] = ~btn_raw[1];
         cyc(2);
      end
      btn_raw[1] = 1'b0;
      cyc(15);
      btn_raw[1] = 1'b1;
      cyc(15);
      btn_raw[2] = 1'b0;
      cyc(25);
      btn_raw[2] = 1'b1;
      cyc(15);
      btn_raw[3] = 1'b0;
      btn_raw[0] = 1'b0;
      cyc(15);
      btn_raw = 4'hF;
      cyc(15);
      evt_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         btn_raw[b] = 1'b0;
         cyc(10);
         if (b < 2) begin
            btn_raw[b] = 1'b1;
            cyc(10);
         end
      end
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      evt_ready = 1'b1;
      cyc(10);
      btn_raw[2] = 1'b1;
      cyc(15);
      evt_ready = 1'b0;
      btn_raw[3] = 1'b0; cyc(10);
      btn_raw[3] = 1'b1; cyc(10);
      btn_raw[0] = 1'b0; cyc(10);
      btn_raw[0] = 1'b1; cyc(10);
      btn_raw[1] = 1'b0;
      for (int t = 0; t < 15; t++) begin
         evt_ready = any_pend();
         cyc(1);
      end
      evt_ready = 1'b1;
      cyc(10);
      btn_raw[1] = 1'b1;
      cyc(15);
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NB; b++)
            if ($urandom_range(0, 24) == 0) btn_raw[b] = ~btn_raw[b];
         evt_ready = $urandom_range(0, 3) != 0;
         overflow_clr = $urandom_range(0, 40) == 0;
         rst_n = $urandom_range(0, 700) != 0;
         cyc(1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
